// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and state types for the CPU character I/O port
package io_pkg;

    localparam int BITS      = 16;
    localparam int CHAR_BITS = 8;

    localparam logic FGI_RST = 1'b0;
    localparam logic FGO_RST = 1'b1;

    // Encoded so that the state bit equals FGI
    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_e;

    // Encoded so that the state bit equals FGO
    typedef enum logic {
        OUT_PEND = 1'b0,
        OUT_IDLE = 1'b1
    } out_state_e;

endpackage

// File: rtl/io_port_if.sv
// rtl/io_port_if.sv - bundle of device handshakes and CPU control lines of the I/O port
interface io_port_if #(
    parameter int Bits     = 16,
    parameter int CharBits = 8
);
    // input device
    logic [CharBits-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    // output device
    logic [CharBits-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    // CPU datapath / sequencer
    logic [Bits-1:0]     inpr;
    logic [CharBits-1:0] ac_lo;
    logic                cpu_inp;
    logic                cpu_out;
    logic                ien_set;
    logic                ien_clr;
    logic                r_window;
    logic                int_ack;
    logic                fgi;
    logic                fgo;
    logic                ien;
    logic                r;

    modport slave (
        input  in_data, in_valid, out_ready, ac_lo, cpu_inp, cpu_out,
               ien_set, ien_clr, r_window, int_ack,
        output in_ready, out_data, out_valid, inpr, fgi, fgo, ien, r
    );

    modport master (
        output in_data, in_valid, out_ready, ac_lo, cpu_inp, cpu_out,
               ien_set, ien_clr, r_window, int_ack,
        input  in_ready, out_data, out_valid, inpr, fgi, fgo, ien, r
    );

endinterface

// File: rtl/io_char_reg.sv
// rtl/io_char_reg.sv - character-wide holding register with load enable
module io_char_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture a new character only when explicitly loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/io_port.sv
// rtl/io_port.sv - INPR/OUTR character port with FGI/FGO, IEN and interrupt request R
module io_port
    import io_pkg::*;
#(
    parameter int Bits     = BITS,
    parameter int CharBits = CHAR_BITS
) (
    input  logic      clk,
    input  logic      rst_n,
    io_port_if.slave  bus
);

    in_state_e           r_in_state;
    in_state_e           w_in_state_nxt;
    out_state_e          r_out_state;
    out_state_e          w_out_state_nxt;
    logic                w_inpr_load;
    logic                w_outr_load;
    logic                w_fgi;
    logic                w_fgo;
    logic                r_ien;
    logic                r_r;
    logic [CharBits-1:0] w_inpr_q;
    logic [CharBits-1:0] w_outr_q;

    // Flag state registers; reset values come from the package flag constants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_state  <= in_state_e'(FGI_RST);
            r_out_state <= out_state_e'(FGO_RST);
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
        end
    end

    // Input side: accept one character when empty, hold it until INP drains it
    always_comb begin
        w_in_state_nxt = r_in_state;
        w_inpr_load    = 1'b0;
        case (r_in_state)
            IN_EMPTY: begin
                if (bus.in_valid) begin
                    w_inpr_load    = 1'b1;
                    w_in_state_nxt = IN_FULL;
                end
            end
            IN_FULL: begin
                if (bus.cpu_inp) begin
                    w_in_state_nxt = IN_EMPTY;
                end
            end
            default: w_in_state_nxt = IN_EMPTY;
        endcase
    end

    // Output side: OUT always reloads OUTR (even over an unsent character), device drains it
    always_comb begin
        w_out_state_nxt = r_out_state;
        w_outr_load     = bus.cpu_out;
        case (r_out_state)
            OUT_IDLE: begin
                if (bus.cpu_out) begin
                    w_out_state_nxt = OUT_PEND;
                end
            end
            OUT_PEND: begin
                if (!bus.cpu_out && bus.out_ready) begin
                    w_out_state_nxt = OUT_IDLE;
                end
            end
            default: w_out_state_nxt = OUT_IDLE;
        endcase
    end

    assign w_fgi = (r_in_state == IN_FULL);
    assign w_fgo = (r_out_state == OUT_IDLE);

    // IEN: interrupt acknowledge and IOF both beat ION
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ien <= 1'b0;
        end else if (bus.int_ack || bus.ien_clr) begin
            r_ien <= 1'b0;
        end else if (bus.ien_set) begin
            r_ien <= 1'b1;
        end
    end

    // R: sticky request from pre-edge flags, cleared only by interrupt acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= 1'b0;
        end else if (bus.int_ack) begin
            r_r <= 1'b0;
        end else if (r_ien && (w_fgi || w_fgo) && bus.r_window) begin
            r_r <= 1'b1;
        end
    end

    io_char_reg #(.W(CharBits)) u_inpr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_inpr_load),
        .i_d    (bus.in_data),
        .o_q    (w_inpr_q)
    );

    io_char_reg #(.W(CharBits)) u_outr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_outr_load),
        .i_d    (bus.ac_lo),
        .o_q    (w_outr_q)
    );

    // Zero-extend INPR onto the CPU datapath
    always_comb begin
        bus.inpr                 = '0;
        bus.inpr[CharBits-1:0]   = w_inpr_q;
    end

    assign bus.in_ready  = ~w_fgi;
    assign bus.out_valid = ~w_fgo;
    assign bus.out_data  = w_outr_q;
    assign bus.fgi       = w_fgi;
    assign bus.fgo       = w_fgo;
    assign bus.ien       = r_ien;
    assign bus.r         = r_r;

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - randomized scoreboard bench for io_port
module tb_io_port;

    typedef struct packed {
        logic       fgi;
        logic       fgo;
        logic       ien;
        logic       r;
        logic [7:0] inpr;
        logic [7:0] outr;
    } snap_t;

    logic clk;
    logic rst_n;

    io_port_if #(.Bits(16), .CharBits(8)) bus ();

    io_port #(.Bits(16), .CharBits(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    snap_t model;
    snap_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model = '{fgi: 1'b0, fgo: 1'b1, ien: 1'b0, r: 1'b0, inpr: 8'h00, outr: 8'h00};
    endtask

    // Scoreboard monitor: every cycle with a pending expectation is compared after the edge
    always @(posedge clk) begin
        snap_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_fgi",       32'(bus.fgi),       32'(e.fgi));
            chk("sb_fgo",       32'(bus.fgo),       32'(e.fgo));
            chk("sb_in_ready",  32'(bus.in_ready),  32'(!e.fgi));
            chk("sb_out_valid", 32'(bus.out_valid), 32'(!e.fgo));
            chk("sb_ien",       32'(bus.ien),       32'(e.ien));
            chk("sb_r",         32'(bus.r),         32'(e.r));
            chk("sb_inpr",      32'(bus.inpr),      {24'h0, e.inpr});
            chk("sb_out_data",  32'(bus.out_data),  {24'h0, e.outr});
        end
    end

    task automatic cyc(input bit iv, input logic [7:0] id, input bit cinp, input bit cout,
                       input logic [7:0] ac, input bit ordy, input bit iset, input bit iclr,
                       input bit rwin, input bit ack);
        snap_t nx;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.cpu_inp   = cinp;
        bus.cpu_out   = cout;
        bus.ac_lo     = ac;
        bus.out_ready = ordy;
        bus.ien_set   = iset;
        bus.ien_clr   = iclr;
        bus.r_window  = rwin;
        bus.int_ack   = ack;
        nx = model;
        if (!model.fgi && iv) begin
            nx.inpr = id;
            nx.fgi  = 1'b1;
        end else if (model.fgi && cinp) begin
            nx.fgi = 1'b0;
        end
        if (cout) begin
            nx.outr = ac;
            nx.fgo  = 1'b0;
        end else if (!model.fgo && ordy) begin
            nx.fgo = 1'b1;
        end
        if (ack || iclr)      nx.ien = 1'b0;
        else if (iset)        nx.ien = 1'b1;
        if (ack)              nx.r = 1'b0;
        else if (model.ien && (model.fgi || model.fgo) && rwin) nx.r = 1'b1;
        model = nx;
        sb.push_back(nx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Assert reset between edges while a character is being offered
    task automatic reset_mid_transfer(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        bus.cpu_out  = 1'b0;
        bus.cpu_inp  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        chk({tag, "_fgi"},       32'(bus.fgi),       0);
        chk({tag, "_fgo"},       32'(bus.fgo),       1);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_inpr"},      32'(bus.inpr),      0);
        chk({tag, "_out_data"},  32'(bus.out_data),  0);
        chk({tag, "_ien"},       32'(bus.ien),       0);
        chk({tag, "_r"},         32'(bus.r),         0);
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_data = 0; bus.cpu_inp = 0; bus.cpu_out = 0;
        bus.ac_lo = 0; bus.out_ready = 0; bus.ien_set = 0; bus.ien_clr = 0;
        bus.r_window = 0; bus.int_ack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Input handshake, ignored second offer, INP drain
        cyc(1, 8'h41, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        after_edge();
        chk("in_inpr",     32'(bus.inpr),     32'h0041);
        chk("in_fgi",      32'(bus.fgi),      1);
        chk("in_ready_lo", 32'(bus.in_ready), 0);
        cyc(1, 8'h42, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        after_edge();
        chk("in_ignored",  32'(bus.inpr),     32'h0041);
        cyc(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        after_edge();
        chk("inp_ready",   32'(bus.in_ready), 1);

        // Output handshake with back-pressure
        cyc(0, 8'h00, 0, 1, 8'h5A, 0, 0, 0, 0, 0);
        after_edge();
        chk("out_valid",   32'(bus.out_valid), 1);
        chk("out_data",    32'(bus.out_data),  32'h5A);
        idle(3);
        after_edge();
        chk("out_hold",    32'(bus.out_data),  32'h5A);
        chk("out_hold_v",  32'(bus.out_valid), 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        after_edge();
        chk("out_fgo",     32'(bus.fgo),       1);

        // Load collides with consumption
        cyc(0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 8'h22, 1, 0, 0, 0, 0);
        after_edge();
        chk("coll_data",   32'(bus.out_data),  32'h22);
        chk("coll_valid",  32'(bus.out_valid), 1);

        // Interrupt request and acknowledge
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        after_edge();
        chk("int_r_set",   32'(bus.r),   1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 1);
        after_edge();
        chk("int_ack_r",   32'(bus.r),   0);
        chk("int_ack_ien", 32'(bus.ien), 0);

        // Priorities: clear beats set; no request outside the window
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        after_edge();
        chk("prio_ien",    32'(bus.ien), 0);
        cyc(1, 8'h77, 0, 0, 8'h00, 0, 1, 0, 0, 0);
        idle(3);
        after_edge();
        chk("nowin_r",     32'(bus.r),   0);
        chk("nowin_fgi",   32'(bus.fgi), 1);

        reset_mid_transfer("rst1");

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) reset_mid_transfer("rst2");
            cyc($urandom_range(0, 1) == 1, 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 8'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_port.md
# io_port

Character I/O interface of the hardwired CPU. It captures 8-bit characters from an external input device into INPR, where the ALU's INPR operation reads them, and sends AC[7:0] to an external output device through OUTR. It also maintains the FGI/FGO flags, the interrupt-enable flip-flop IEN and the interrupt-request flip-flop R for the control sequencer.

## Interface
- Bits, 16: CPU datapath width; width of `inpr`.
- CharBits, 8: device character width; must be ≤ Bits.

- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  CharBits  character from input device.
- in_valid  in  1  input device offers `in_data`.
- in_ready  out  1  port can accept a character; equals ~FGI.
- out_data  out  CharBits  OUTR contents.
- out_valid  out  1  OUTR holds an unsent character; equals ~FGO.
- out_ready  in  1  output device accepts `out_data`.
- inpr  out  Bits  {zeros, INPR}; feeds ALU INPR operand.
- ac_lo  in  CharBits  AC[7:0], source for OUT.
- cpu_inp  in  1  INP executed: clear FGI.
- cpu_out  in  1  OUT executed: load OUTR from `ac_lo`, clear FGO.
- ien_set / ien_clr  in  1 each  ION / IOF.
- r_window  in  1  sequencer outside T0–T2; R may be set.
- int_ack  in  1  interrupt cycle entered: clear R and IEN.
- fgi, fgo, ien, r  out  1 each  flag flip-flops, for SKI/SKO and the sequencer.

## Operation
- Input side has two states, EMPTY (FGI=0) and FULL (FGI=1).
  - EMPTY & in_valid: INPR←in_data, FGI←1.
  - FULL & cpu_inp: FGI←0.
  - cpu_inp in EMPTY: no effect.
  - in_valid in FULL: ignored. The device holds its data.
- Output side has two states, IDLE (FGO=1) and PEND (FGO=0).
  - cpu_out in either state: OUTR←ac_lo, FGO←0.
  - PEND & out_ready: FGO←1 (character consumed).
  - PEND & out_ready & cpu_out in the same cycle: the old character is consumed, the new one is loaded, and FGO stays 0.
  - cpu_out in PEND without out_ready: OUTR is overwritten. The previous character is lost; software must poll SKO.
- IEN:
  - ien_set → 1; ien_clr → 0.
  - int_ack → 0, with priority over ien_set.
  - ien_set & ien_clr together: clear wins.
- R:
  - Set when IEN & (FGI|FGO) & r_window, using pre-edge flag values.
  - Cleared by int_ack, which has priority over set.
  - R holds when the set condition drops.
- INPR and OUTR change only on the loads listed above.

## Timing
- Reset values: FGI=0, FGO=1, IEN=0, R=0, INPR=0, OUTR=0. Hence in_ready=1, out_valid=0, inpr=0, out_data=0.
- Reset asserted mid-transfer aborts it immediately; no handshake completes on the deassertion edge.
- Input handshake: a transfer completes on the edge where in_valid & in_ready. `inpr` and `fgi` show the new value the following cycle, and in_ready drops the same cycle.
- INP→ready: in_ready rises one cycle after cpu_inp.
- Output handshake: a transfer completes on the edge where out_valid & out_ready. OUT→device: out_valid rises one cycle after cpu_out.
- R latency: one cycle after the condition is true.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Structure
- Package `io_pkg`:
  - CHAR_BITS default.
  - Flag reset constants (FGI_RST=0, FGO_RST=1).
  - Input-state and output-state enums.
- Sub-module `io_char_reg` (CharBits-wide register with async reset and load enable), instantiated twice: INPR and OUTR.
- Flags, IEN and R live in the top module.

## Test plan
- Reset: drive rst_n=0 mid-transfer (in_valid=1) → fgi=0, fgo=1, in_ready=1, out_valid=0, inpr=0, r=0 immediately.
- Input: in_data=8'h41 with in_valid for 1 cycle → next cycle inpr=16'h0041, fgi=1, in_ready=0. Then offer 8'h42 → ignored. Then cpu_inp → in_ready=1 one cycle later.
- Output: ac_lo=8'h5A, cpu_out → out_valid=1, out_data=8'h5A. Hold out_ready=0 for 3 cycles → unchanged. Then out_ready=1 → fgo=1 next cycle.
- Collision: PEND with out_data=8'h11; cpu_out with ac_lo=8'h22 and out_ready together → out_data=8'h22, out_valid stays 1.
- Interrupt: ien_set, r_window=1, FGO=1 → r=1 one cycle later. int_ack together with ien_set → r=0, ien=0.
- Priority: ien_set & ien_clr in the same cycle → ien=0. r_window=0 with IEN & FGI → r stays 0.
